// File: rtl/niosii_multi_timer_pkg.sv
// Shared register offsets and bit positions for the multi-channel interval timer.
package niosii_multi_timer_pkg;

   localparam logic [2:0] REG_STATUS   = 3'd0;
   localparam logic [2:0] REG_CONTROL  = 3'd1;
   localparam logic [2:0] REG_PERIOD   = 3'd2;
   localparam logic [2:0] REG_SNAP     = 3'd3;
   localparam logic [2:0] REG_PRESCALE = 3'd4;

   localparam int CTRL_ITO   = 0;
   localparam int CTRL_CONT  = 1;
   localparam int CTRL_START = 2;
   localparam int CTRL_STOP  = 3;

   localparam int STAT_TO  = 0;
   localparam int STAT_RUN = 1;

endpackage

// File: rtl/niosii_multi_timer_if.sv
// Avalon-MM slave bus of the multi-channel timer.
interface niosii_multi_timer_if #(
   parameter int ADDR_W = 5
);
   // Write when chipselect & !write_n; readdata is valid one cycle after the
   // address is presented, with no wait states and no read strobe needed.
   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [31:0]       writedata;
   logic [31:0]       readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/niosii_timer_channel.sv
// One timer channel: prescaler, reloading down-counter, RUN/TO flags and the
// channel's registers, driven by write strobes already decoded by the top.
module niosii_timer_channel
   import niosii_multi_timer_pkg::*;
#(
   parameter int CNT_W        = 32,
   parameter int PRE_W        = 8,
   parameter int RESET_PERIOD = 99
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_status,
   input  logic             wr_control,
   input  logic             wr_period,
   input  logic             wr_snap,
   input  logic             wr_prescale,
   input  logic [31:0]      wdata,
   output logic [1:0]       status,
   output logic [3:0]       control,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] snap,
   output logic [PRE_W-1:0] prescale,
   output logic             irq
);

   logic [CNT_W-1:0] count_q, count_d, period_q, period_d, snap_q, snap_d;
   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d, prescale_q, prescale_d;
   logic             run_q, run_d, to_q, to_d, cont_q, cont_d, ito_q, ito_d;
   logic             start, stop, tick, timeout;

   always_comb begin
      start   = wr_control & wdata[CTRL_START];
      stop    = wr_control & wdata[CTRL_STOP];
      // A START write restarts the prescaler, so that cycle never ticks.
      tick    = run_q & ~start & (pre_cnt_q == '0);
      timeout = tick & (count_q == '0);

      pre_cnt_d = pre_cnt_q;
      if (start)
         pre_cnt_d = prescale_q;
      else if (run_q)
         pre_cnt_d = tick ? prescale_q : pre_cnt_q - PRE_W'(1);

      count_d = count_q;
      if (wr_period)
         count_d = wdata[CNT_W-1:0];
      else if (tick)
         count_d = timeout ? period_q : count_q - CNT_W'(1);

      run_d = run_q;
      if (start)
         run_d = 1'b1;
      else if (stop || wr_period)
         run_d = 1'b0;
      else if (timeout && !cont_q)
         run_d = 1'b0;

      // A timeout in the same cycle as a STATUS write keeps TO set.
      to_d       = timeout | (to_q & ~wr_status);
      cont_d     = wr_control ? wdata[CTRL_CONT] : cont_q;
      ito_d      = wr_control ? wdata[CTRL_ITO] : ito_q;
      period_d   = wr_period ? wdata[CNT_W-1:0] : period_q;
      snap_d     = wr_snap ? count_q : snap_q;
      prescale_d = wr_prescale ? wdata[PRE_W-1:0] : prescale_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q    <= CNT_W'(RESET_PERIOD);
         period_q   <= CNT_W'(RESET_PERIOD);
         snap_q     <= '0;
         pre_cnt_q  <= '0;
         prescale_q <= '0;
         run_q      <= 1'b0;
         to_q       <= 1'b0;
         cont_q     <= 1'b0;
         ito_q      <= 1'b0;
      end else begin
         count_q    <= count_d;
         period_q   <= period_d;
         snap_q     <= snap_d;
         pre_cnt_q  <= pre_cnt_d;
         prescale_q <= prescale_d;
         run_q      <= run_d;
         to_q       <= to_d;
         cont_q     <= cont_d;
         ito_q      <= ito_d;
      end
   end

   always_comb begin
      status              = '0;
      status[STAT_RUN]    = run_q;
      status[STAT_TO]     = to_q;
      control             = '0;
      control[CTRL_CONT]  = cont_q;
      control[CTRL_ITO]   = ito_q;
   end

   assign period   = period_q;
   assign snap     = snap_q;
   assign prescale = prescale_q;
   assign irq      = to_q & ito_q;

endmodule

// File: rtl/niosii_multi_timer.sv
// Multi-channel interval timer: address decode, registered read mux and IRQ
// combining around NUM_CH independent timer channels.
module niosii_multi_timer
   import niosii_multi_timer_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int CNT_W        = 32,
   parameter int PRE_W        = 8,
   parameter int RESET_PERIOD = 99
) (
   input  logic                 clk,
   input  logic                 reset,
   niosii_multi_timer_if.slave  bus,
   output logic [NUM_CH-1:0]    irq_vec,
   output logic                 irq
);

   localparam int ADDR_W = $clog2(NUM_CH) + 3;

   logic [ADDR_W-1:0] ch_sel;
   logic [2:0]        reg_sel;
   logic              wr_en;
   logic [31:0]       readdata_q, readdata_d;

   logic [NUM_CH-1:0][1:0]       status_a;
   logic [NUM_CH-1:0][3:0]       control_a;
   logic [NUM_CH-1:0][CNT_W-1:0] period_a;
   logic [NUM_CH-1:0][CNT_W-1:0] snap_a;
   logic [NUM_CH-1:0][PRE_W-1:0] prescale_a;

   assign ch_sel  = bus.address >> 3;
   assign reg_sel = bus.address[2:0];
   assign wr_en   = bus.chipselect & ~bus.write_n;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic sel;
      assign sel = wr_en && (ch_sel == ADDR_W'(g));

      niosii_timer_channel #(
         .CNT_W        (CNT_W),
         .PRE_W        (PRE_W),
         .RESET_PERIOD (RESET_PERIOD)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .wr_status   (sel && (reg_sel == REG_STATUS)),
         .wr_control  (sel && (reg_sel == REG_CONTROL)),
         .wr_period   (sel && (reg_sel == REG_PERIOD)),
         .wr_snap     (sel && (reg_sel == REG_SNAP)),
         .wr_prescale (sel && (reg_sel == REG_PRESCALE)),
         .wdata       (bus.writedata),
         .status      (status_a[g]),
         .control     (control_a[g]),
         .period      (period_a[g]),
         .snap        (snap_a[g]),
         .prescale    (prescale_a[g]),
         .irq         (irq_vec[g])
      );
   end

   // Channel indices with no channel behind them fall through to zero.
   always_comb begin
      readdata_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_sel == ADDR_W'(i)) begin
            case (reg_sel)
               REG_STATUS:   readdata_d = 32'(status_a[i]);
               REG_CONTROL:  readdata_d = 32'(control_a[i]);
               REG_PERIOD:   readdata_d = 32'(period_a[i]);
               REG_SNAP:     readdata_d = 32'(snap_a[i]);
               REG_PRESCALE: readdata_d = 32'(prescale_a[i]);
               default:      readdata_d = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         readdata_q <= '0;
      else
         readdata_q <= readdata_d;
   end

   assign bus.readdata = readdata_q;
   assign irq          = |irq_vec;

endmodule

// File: tb/tb_niosii_multi_timer.sv
// Bench for niosii_multi_timer: directed scenarios then random bus traffic,
// checked against a timeline model that derives counter state from elapsed cycles.
module tb_niosii_multi_timer;
   localparam int NCH = 5;
   localparam int AW  = $clog2(NCH) + 3;
   localparam int RP  = 99;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [NCH-1:0] irq_vec;
   logic           irq;
   int             cyc = 0;
   int             n_checks = 0;
   int             n_fail = 0;

   niosii_multi_timer_if #(.ADDR_W(AW)) bus ();

   niosii_multi_timer #(
      .NUM_CH(NCH), .CNT_W(32), .PRE_W(8), .RESET_PERIOD(RP)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus), .irq_vec(irq_vec), .irq(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Per channel: a running segment started in cycle m_s with count m_c0; tick k
   // lands in cycle m_s + k*(pre+1). Stopped channels hold their count in m_c0.
   int m_period[NCH], m_pre[NCH], m_cont[NCH], m_ito[NCH], m_snap[NCH];
   int m_run[NCH], m_s[NCH], m_c0[NCH], m_lt[NCH], m_clr[NCH];

   task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_period[i] = RP; m_c0[i] = RP; m_pre[i] = 0; m_cont[i] = 0; m_ito[i] = 0;
         m_snap[i] = 0; m_run[i] = 0; m_s[i] = 0; m_lt[i] = -1; m_clr[i] = -1;
      end
   endfunction

   function automatic int ticks(int ch, int n);
      int k;
      if (m_run[ch] == 0 || n - 1 < m_s[ch]) return 0;
      k = (n - 1 - m_s[ch]) / (m_pre[ch] + 1);
      if (m_cont[ch] == 0 && k > m_c0[ch] + 1) k = m_c0[ch] + 1;
      return k;
   endfunction

   function automatic int cnt_after(int ch, int k);
      if (k <= m_c0[ch]) return m_c0[ch] - k;
      return m_period[ch] - ((k - m_c0[ch] - 1) % (m_period[ch] + 1));
   endfunction

   function automatic int last_to(int ch, int k);
      int j;
      if (k < m_c0[ch] + 1) return -1;
      j = (k - m_c0[ch] - 1) / (m_period[ch] + 1);
      return m_s[ch] + (m_c0[ch] + 1 + j * (m_period[ch] + 1)) * (m_pre[ch] + 1);
   endfunction

   function automatic bit to_at(int ch, int n);
      int lt, t;
      lt = m_lt[ch];
      if (m_run[ch] != 0) begin
         t = last_to(ch, ticks(ch, n));
         if (t > lt) lt = t;
      end
      return (lt >= 0) && (lt >= m_clr[ch]);
   endfunction

   function automatic bit run_at(int ch, int n);
      if (m_run[ch] == 0) return 1'b0;
      return !(m_cont[ch] == 0 && ticks(ch, n) >= m_c0[ch] + 1);
   endfunction

   function automatic int count_at(int ch, int n);
      return (m_run[ch] != 0) ? cnt_after(ch, ticks(ch, n)) : m_c0[ch];
   endfunction

   function automatic void freeze(int ch, int k);
      int t;
      if (m_run[ch] == 0) return;
      t = last_to(ch, k);
      if (t > m_lt[ch]) m_lt[ch] = t;
      m_c0[ch]  = cnt_after(ch, k);
      m_run[ch] = 0;
   endfunction

   function automatic void normalize(int ch, int w);
      if (m_run[ch] != 0 && m_cont[ch] == 0 && ticks(ch, w) >= m_c0[ch] + 1)
         freeze(ch, m_c0[ch] + 1);
   endfunction

   function automatic int next_to(int ch, int n);
      int c;
      for (int j = 0; j < 1000; j++) begin
         c = m_s[ch] + (m_c0[ch] + 1 + j * (m_period[ch] + 1)) * (m_pre[ch] + 1);
         if (c >= n) return c;
      end
      return n;
   endfunction

   function automatic void model_write(int ch, int off, logic [31:0] d, int w);
      if (ch >= NCH) return;
      normalize(ch, w);
      case (off)
         0: m_clr[ch] = w;
         1: begin
            if (d[2]) begin
               freeze(ch, ticks(ch, w));
               m_run[ch] = 1;
               m_s[ch]   = w;
            end else if (d[3]) begin
               freeze(ch, ticks(ch, w + 1));
            end
            m_cont[ch] = int'(d[1]);
            m_ito[ch]  = int'(d[0]);
         end
         2: begin
            freeze(ch, ticks(ch, w + 1));
            m_period[ch] = int'(d);
            m_c0[ch]     = int'(d);
         end
         3: m_snap[ch] = count_at(ch, w);
         4: m_pre[ch] = int'(d & 32'hff);
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] exp_read(int ch, int off, int n);
      logic [31:0] r;
      r = '0;
      if (ch >= NCH) return r;
      case (off)
         0: begin r[1] = run_at(ch, n); r[0] = to_at(ch, n); end
         1: begin r[1] = (m_cont[ch] != 0); r[0] = (m_ito[ch] != 0); end
         2: r = 32'(m_period[ch]);
         3: r = 32'(m_snap[ch]);
         4: r = 32'(m_pre[ch]);
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic check_irqs(int n);
      logic [NCH-1:0] ev;
      for (int i = 0; i < NCH; i++) ev[i] = to_at(i, n) && (m_ito[i] != 0);
      check_eq("irq_vec", 32'(irq_vec), 32'(ev));
      check_eq("irq", 32'(irq), 32'(|ev));
   endtask

   task automatic bus_idle();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.address    = '0;
      bus.writedata  = '0;
   endtask

   task automatic idle(int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic idle_to(int target);
      while (cyc < target - 1) begin @(posedge clk); #1; end
   endtask

   task automatic wr(int ch, int off, logic [31:0] d, bit sanitize = 1'b0);
      int w;
      @(posedge clk); #1;
      w = cyc;
      if (sanitize && ch < NCH) begin
         normalize(ch, w);
         if (off == 4 && m_run[ch] != 0) off = 3;
         if (off == 1 && m_run[ch] != 0 && d[3:2] == 2'b00) d[1] = (m_cont[ch] != 0);
      end
      check_irqs(w);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.address    = AW'(ch * 8 + off);
      bus.writedata  = d;
      model_write(ch, off, d, w);
      @(posedge clk); #1;
      bus_idle();
   endtask

   task automatic rd(int ch, int off, string tag);
      int n;
      logic [31:0] e;
      @(posedge clk); #1;
      n = cyc;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      bus.address    = AW'(ch * 8 + off);
      e = exp_read(ch, off, n);
      check_irqs(n);
      @(posedge clk); #1;
      bus_idle();
      check_eq(tag, bus.readdata, e);
   endtask

   initial begin
      int t;
      bus_idle();
      model_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_readdata", bus.readdata, 32'h0);
      check_eq("rst_irq", 32'(irq), 32'h0);
      check_eq("rst_irq_vec", 32'(irq_vec), 32'h0);
      reset = 1'b0;

      rd(0, 2, "ch0_period_rst");
      rd(0, 0, "ch0_status_rst");

      // ch1: continuous with interrupts, 10-cycle period
      wr(1, 2, 32'd9);
      wr(1, 4, 32'd0);
      wr(1, 1, 32'h7);
      for (int i = 0; i < 10; i++) rd(1, 0, "ch1_status");
      wr(1, 0, 32'h0);
      rd(1, 0, "ch1_status_clr");
      for (int i = 0; i < 6; i++) rd(1, 0, "ch1_status2");
      wr(1, 1, 32'h2);
      rd(1, 0, "ch1_status_noito");
      rd(1, 1, "ch1_control");

      // ch2: one-shot, prescale 2
      wr(2, 2, 32'd4);
      wr(2, 4, 32'd2);
      wr(2, 1, 32'h5);
      for (int i = 0; i < 12; i++) rd(2, 0, "ch2_status");
      wr(2, 3, 32'h0);
      rd(2, 3, "ch2_snap");
      rd(2, 4, "ch2_prescale");

      // ch0: period rewrite while running
      wr(0, 1, 32'h6);
      idle(7);
      wr(0, 2, 32'd1000);
      rd(0, 0, "ch0_status_forced");
      wr(0, 3, 32'h0);
      rd(0, 3, "ch0_snap_forced");
      wr(0, 1, 32'h6);
      idle(5);
      wr(0, 3, 32'h0);
      rd(0, 3, "ch0_snap_resumed");

      // ch3: STATUS write landing on the timeout cycle
      wr(3, 2, 32'd6);
      wr(3, 4, 32'd1);
      wr(3, 1, 32'h7);
      t = next_to(3, cyc + 4);
      idle_to(t);
      wr(3, 0, 32'h0);
      rd(3, 0, "ch3_to_kept");

      // Unmapped channel and offsets
      wr(NCH, 2, 32'd7);
      wr(NCH, 1, 32'h7);
      wr(0, 6, 32'hdead_beef);
      rd(NCH, 2, "bad_ch_period");
      rd(NCH, 1, "bad_ch_control");
      rd(0, 6, "ch0_off6");
      rd(0, 2, "ch0_period_kept");

      // Random traffic
      for (int it = 0; it < 300; it++) begin
         int op, ch, off;
         logic [31:0] d;
         op  = $urandom_range(0, 9);
         ch  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, NCH - 1) : $urandom_range(NCH, 7);
         off = $urandom_range(0, 7);
         if (op < 4) begin
            rd(ch, off, "rand_rd");
         end else if (op < 8) begin
            case (off)
               1:       d = 32'($urandom_range(0, 15));
               2:       d = 32'($urandom_range(0, 40));
               4:       d = 32'($urandom_range(0, 3));
               default: d = $urandom;
            endcase
            wr(ch, off, d, 1'b1);
         end else begin
            idle($urandom_range(1, 20));
         end
      end

      // Reset in the middle of counting
      @(posedge clk); #1;
      reset = 1'b1;
      idle(2);
      check_eq("midrst_readdata", bus.readdata, 32'h0);
      check_eq("midrst_irq", 32'(irq), 32'h0);
      reset = 1'b0;
      model_reset();
      rd(1, 0, "post_rst_status");
      idle(12);
      rd(1, 2, "post_rst_period");
      wr(1, 3, 32'h0);
      rd(1, 3, "post_rst_snap");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/niosii_multi_timer.md
Name: niosII_multi_timer

Overview:
Parametrised multi-channel interval timer for the Nios II system, memory-mapped as an Avalon-MM slave. It provides NUM_CH independent down-counters. Each channel has a full-width period register, a programmable clock prescaler, one-shot or continuous mode, a snapshot register and its own interrupt. The block replaces the single fixed 16-bit-interface system clock timer and drives the CPU IRQ lines as a per-channel vector plus one combined line.

Parameters:
NUM_CH, 4, number of independent timer channels (1..8)
CNT_W, 32, counter/period/snapshot width in bits (8..32)
PRE_W, 8, prescaler register width in bits
RESET_PERIOD, 99, reset value of every period register and counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
address  in  $clog2(NUM_CH)+3  {channel, reg[2:0]}
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  registered read data, latency 1
irq_vec  out  NUM_CH  per-channel interrupt
irq  out  1  OR of irq_vec

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: readdata=0, irq_vec=0, irq=0. All counters and period registers = RESET_PERIOD. Control, prescale, snapshot, TO and RUN = 0.
- Register map per channel, reg offset:
  - 0 STATUS: read {RUN,TO} in bits [1:0]. Any write clears TO.
  - 1 CONTROL [3:0] = STOP, START, CONT, ITO. START and STOP are strobes and always read back 0.
  - 2 PERIOD: CNT_W bits; writedata above CNT_W is ignored; reads zero-extend.
  - 3 SNAP: a write captures the live counter; a read returns the captured value.
  - 4 PRESCALE: PRE_W bits.
  - Offsets 5-7 read 0 and ignore writes. Channel indices >= NUM_CH read 0 and ignore writes.
- Reads: readdata updates every cycle from the address mux, regardless of chipselect. Data is valid the cycle after the address is presented; there are no wait states.
- Prescaler, per channel:
  - pre_cnt counts down from PRESCALE while RUN=1; tick=1 when pre_cnt==0, and pre_cnt then reloads.
  - PRESCALE=0 gives a tick every clk.
  - pre_cnt reloads whenever START is written.
- Counter, per channel, on a tick while RUN=1:
  - If count==0: load PERIOD, raise the timeout event, and clear RUN when CONT=0.
  - Otherwise: decrement by 1.
  - The period is therefore (PERIOD+1)*(PRESCALE+1) clk cycles. Wrap is by reload only; the counter never underflows.
- PERIOD write:
  - The next cycle forces count=new PERIOD and clears RUN (force_reload).
  - Software must rewrite START to resume.
- Run state priority:
  - START beats STOP in the same write.
  - START beats force_reload.
  - A START write while running restarts the prescaler without reloading the counter.
- TO flag: set on the timeout event. If a timeout event and a STATUS write land in the same cycle, the set wins so no interrupt is lost.
- Interrupts: irq_vec[i] = TO[i] & ITO[i], combinational from registers. Clearing ITO drops the irq but leaves TO set.
- Independence: channels are fully independent. Simultaneous timeouts on several channels each set their own TO.
- Reset mid-count: all state returns immediately to reset values, and the counters do not run until START.

Decomposition:
- Package niosII_multi_timer_pkg holds:
  - register offset constants REG_STATUS..REG_PRESCALE;
  - control bit indices CTRL_ITO, CTRL_CONT, CTRL_START, CTRL_STOP;
  - status bit indices.
- Sub-module niosII_timer_channel, instantiated NUM_CH times in a generate loop, contains the prescaler, counter, RUN/TO flags and per-channel registers, and takes decoded write strobes.
- The top level holds only the address decode, read mux, readdata register and irq OR.

Test Plan:
- Reset, then read ch0 PERIOD and STATUS -> readdata 99 and 0 one cycle after each read; irq=0.
- ch1:
  - Stimulus: PERIOD=9, PRESCALE=0, CONTROL=0b0111 (START, CONT, ITO).
  - Response: TO and irq_vec[1] rise every 10 clk; a STATUS write clears the irq; RUN stays 1.
- ch2:
  - Stimulus: PERIOD=4, PRESCALE=2, CONTROL=0b0101 (one-shot).
  - Response: TO after 15 clk; RUN=0; counter holds 4; no further events.
- ch0:
  - Stimulus: running; write PERIOD=1000 mid-count.
  - Response: next cycle RUN=0 and SNAP capture reads 1000; START resumes counting from 1000.
- STATUS-write clear in the same cycle as a ch3 timeout -> TO remains 1.
- Write to channel index NUM_CH, or to offset 6 -> no register changes; readdata 0.
